// File: rtl/tdm_demux8.sv
// ============================================================================
// Module   : tdm_demux8
// Brief    : Scanning serial-to-parallel receiver for a remote 8:1 mux link.
//            Optional macro TDM_DEMUX_CONTINUOUS_EN enables free-running scan.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdm_demux8 #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       gate_n,
    input  logic       din,
    output logic [2:0] sel,
    output logic       strobe_n,
    output logic       busy,
    output logic [7:0] q,
    output logic       valid
);

    localparam logic [3:0] c_settle    = 4'(SETTLE);
    localparam logic [2:0] c_last_slot = 3'd7;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t     r_state;
    logic [2:0] r_slot;
    logic [3:0] r_cnt;
    logic [6:0] r_shadow;
    logic       r_strobe_n;
    logic       r_busy;
    logic [7:0] r_q;
    logic       r_valid;

    // The slot counter doubles as the remote address, so sel only moves on sample edges.
    assign sel      = r_slot;
    assign strobe_n = r_strobe_n;
    assign busy     = r_busy;
    assign q        = r_q;
    assign valid    = r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_slot     <= 3'd0;
            r_cnt      <= 4'd0;
            r_shadow   <= 7'd0;
            r_strobe_n <= 1'b1;
            r_busy     <= 1'b0;
            r_q        <= 8'h00;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !gate_n) begin
                        r_state    <= SCAN;
                        r_slot     <= 3'd0;
                        r_cnt      <= 4'd0;
                        r_shadow   <= 7'd0;
                        r_strobe_n <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                SCAN: begin
                    if (gate_n) begin
                        // Abort wins over a coincident slot-7 sample: q is left untouched.
                        r_state    <= IDLE;
                        r_slot     <= 3'd0;
                        r_cnt      <= 4'd0;
                        r_shadow   <= 7'd0;
                        r_strobe_n <= 1'b1;
                        r_busy     <= 1'b0;
                    end else if (r_cnt < c_settle) begin
                        r_cnt <= r_cnt + 4'd1;
                    end else begin
                        r_cnt  <= 4'd0;
                        r_slot <= r_slot + 3'd1;
                        if (r_slot == c_last_slot) begin
                            r_q      <= {din, r_shadow};
                            r_valid  <= 1'b1;
                            r_shadow <= 7'd0;
`ifdef TDM_DEMUX_CONTINUOUS_EN
                            r_state  <= SCAN;
`else
                            r_state    <= IDLE;
                            r_strobe_n <= 1'b1;
                            r_busy     <= 1'b0;
`endif
                        end else begin
                            for (int i = 0; i < 7; i++) begin
                                if (r_slot == 3'(i)) begin
                                    r_shadow[i] <= din;
                                end
                            end
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux8.sv
// ============================================================================
// Module   : tb_tdm_demux8
// Brief    : Self-checking bench for tdm_demux8 (SETTLE=1 and SETTLE=0 units).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tdm_demux8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_a, gate_n_a, din_a, glitch_a;
    logic [7:0] mux_a;
    logic [2:0] sel_a;
    logic       strobe_n_a, busy_a, valid_a;
    logic [7:0] q_a;

    logic       start_b, gate_n_b, din_b;
    logic [7:0] mux_b;
    logic [2:0] sel_b;
    logic       strobe_n_b, busy_b, valid_b;
    logic [7:0] q_b;

    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    logic [7:0] last_q_a;
    int         errors = 0;
    int         checks = 0;

    tdm_demux8 #(.SETTLE(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .gate_n(gate_n_a), .din(din_a),
        .sel(sel_a), .strobe_n(strobe_n_a), .busy(busy_a), .q(q_a), .valid(valid_a)
    );

    tdm_demux8 #(.SETTLE(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .gate_n(gate_n_b), .din(din_b),
        .sel(sel_b), .strobe_n(strobe_n_b), .busy(busy_b), .q(q_b), .valid(valid_b)
    );

    // Remote mux models: strobe high forces Y low; glitch_a inverts Y on demand.
    always_comb din_a = (strobe_n_a ? 1'b0 : mux_a[sel_a]) ^ glitch_a;
    always_comb din_b = strobe_n_b ? 1'b0 : mux_b[sel_b];

    task automatic test_reset;
        rst_n = 1'b0;
        start_a = 1'b0; gate_n_a = 1'b0; mux_a = 8'h00; glitch_a = 1'b0;
        start_b = 1'b0; gate_n_b = 1'b0; mux_b = 8'h00;
        last_q_a = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({sel_a, strobe_n_a, busy_a, valid_a, q_a} !== {3'd0, 1'b1, 1'b0, 1'b0, 8'h00})
            begin errors++; $display("FAIL reset_a: got %h required %h",
                {sel_a, strobe_n_a, busy_a, valid_a, q_a}, {3'd0, 1'b1, 1'b0, 1'b0, 8'h00}); end
        checks++;
        if ({sel_b, strobe_n_b, busy_b, valid_b, q_b} !== {3'd0, 1'b1, 1'b0, 1'b0, 8'h00})
            begin errors++; $display("FAIL reset_b: got %h required %h",
                {sel_b, strobe_n_b, busy_b, valid_b, q_b}, {3'd0, 1'b1, 1'b0, 1'b0, 8'h00}); end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One SETTLE=1 frame; cycle n lies between edges k+n-1 and k+n after start edge k.
    task automatic run_frame_a(input logic [7:0] v, input bit glitch);
        logic [7:0] e;
        logic [5:0] want;
        @(posedge clk);
        #1 mux_a = v; start_a = 1'b1;
        exp_a.push_back(v);
        @(posedge clk);
        #1 start_a = 1'b0;
        for (int n = 1; n <= 18; n++) begin
            glitch_a = glitch && (n <= 16) && (n % 2 == 1);
            @(negedge clk);
            if (n <= 16) begin
                want = {3'((n - 1) / 2), 1'b0, 1'b1, 1'b0};
                checks++;
                if ({sel_a, strobe_n_a, busy_a, valid_a} !== want) begin
                    errors++;
                    $display("FAIL scan_cycle%0d: got sel/strb/busy/valid %b required %b",
                             n, {sel_a, strobe_n_a, busy_a, valid_a}, want);
                end
            end else if (n == 17) begin
                checks++;
                if ({valid_a, busy_a, strobe_n_a, sel_a} !== {1'b1, 1'b0, 1'b1, 3'd0}) begin
                    errors++;
                    $display("FAIL valid_timing: got valid/busy/strb/sel %b required 1010000",
                             {valid_a, busy_a, strobe_n_a, sel_a});
                end
                checks++;
                if (exp_a.size() == 0) begin
                    errors++; $display("FAIL q_a_scoreboard: got q=%h with no expected entry", q_a);
                end else begin
                    e = exp_a.pop_front();
                    last_q_a = e;
                    if (q_a !== e) begin
                        errors++; $display("FAIL q_a: got %h required %h", q_a, e);
                    end
                end
            end else begin
                checks++;
                if (valid_a !== 1'b0) begin
                    errors++; $display("FAIL valid_width: got %b required 0", valid_a);
                end
            end
            @(posedge clk);
            #1;
        end
        glitch_a = 1'b0;
    endtask

    task automatic test_single_frame;
        run_frame_a(8'hA5, 1'b0);
    endtask

    task automatic test_glitch;
        run_frame_a(8'h3C, 1'b1);
    endtask

    task automatic test_reset_midscan;
        bit got;
        @(posedge clk);
        #1 mux_a = 8'hFF; start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (sel_a !== 3'd4) begin
            errors++; $display("FAIL midscan_slot: got sel %0d required 4", sel_a);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sel_a, strobe_n_a, busy_a, valid_a, q_a} !== {3'd0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            errors++; $display("FAIL async_reset: got %h required %h",
                {sel_a, strobe_n_a, busy_a, valid_a, q_a}, {3'd0, 1'b1, 1'b0, 1'b0, 8'h00});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        last_q_a = 8'h00;
        got = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (valid_a) got = 1'b1;
        end
        checks++;
        if (got) begin
            errors++; $display("FAIL reset_no_valid: got valid 1 required 0");
        end
        checks++;
        if ({q_a, busy_a, strobe_n_a} !== {8'h00, 1'b0, 1'b1}) begin
            errors++; $display("FAIL reset_after: got q/busy/strb %h required %h",
                {q_a, busy_a, strobe_n_a}, {8'h00, 1'b0, 1'b1});
        end
    endtask

    task automatic test_abort;
        bit got;
        @(posedge clk);
        #1 mux_a = 8'hFF; start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        repeat (10) @(posedge clk);
        #1 gate_n_a = 1'b1;
        checks++;
        if (sel_a !== 3'd5) begin
            errors++; $display("FAIL abort_slot: got sel %0d required 5", sel_a);
        end
        @(posedge clk);
        #1 gate_n_a = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy_a, strobe_n_a, sel_a, valid_a} !== {1'b0, 1'b1, 3'd0, 1'b0}) begin
            errors++; $display("FAIL abort_idle: got busy/strb/sel/valid %b required 0100000",
                               {busy_a, strobe_n_a, sel_a, valid_a});
        end
        got = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (valid_a) got = 1'b1;
        end
        checks++;
        if (got) begin
            errors++; $display("FAIL abort_no_valid: got valid 1 required 0");
        end
        checks++;
        if (q_a !== last_q_a) begin
            errors++; $display("FAIL abort_q_hold: got %h required %h", q_a, last_q_a);
        end
        run_frame_a(8'h0F, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [7:0] e;
        @(posedge clk);
        #1 mux_b = 8'h01; start_b = 1'b1;
        exp_b.push_back(8'h01);
        exp_b.push_back(8'h80);
        @(posedge clk);
        #1;
        for (int n = 1; n <= 20; n++) begin
            if (n == 9)  mux_b = 8'h80;
            if (n == 10) start_b = 1'b0;
            @(negedge clk);
            if (n == 9 || n == 18) begin
                checks++;
                if (valid_b !== 1'b1 || (n == 9 && busy_b !== 1'b0)) begin
                    errors++; $display("FAIL b2b_valid%0d: got valid/busy %b%b required 1/0",
                                       n, valid_b, busy_b);
                end
                checks++;
                if (exp_b.size() == 0) begin
                    errors++; $display("FAIL q_b_scoreboard: got q=%h with no expected entry", q_b);
                end else begin
                    e = exp_b.pop_front();
                    if (q_b !== e) begin
                        errors++; $display("FAIL b2b_q%0d: got %h required %h", n, q_b, e);
                    end
                end
            end else begin
                checks++;
                if (valid_b !== 1'b0 || (n == 10 && busy_b !== 1'b1)) begin
                    errors++; $display("FAIL b2b_cycle%0d: got valid/busy %b%b", n, valid_b, busy_b);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_continuous;
        logic [7:0] e;
        @(posedge clk);
        #1 mux_b = 8'h55; start_b = 1'b1;
        exp_b.push_back(8'h55);
        exp_b.push_back(8'hAA);
        @(posedge clk);
        #1 start_b = 1'b0;
        for (int n = 1; n <= 17; n++) begin
            if (n == 9) mux_b = 8'hAA;
            @(negedge clk);
            checks++;
            if (busy_b !== 1'b1 || strobe_n_b !== 1'b0 || valid_b !== (n == 9 || n == 17)) begin
                errors++; $display("FAIL cont_cycle%0d: got busy/strb/valid %b%b%b",
                                   n, busy_b, strobe_n_b, valid_b);
            end
            if (n == 9 || n == 17) begin
                checks++;
                if (exp_b.size() == 0) begin
                    errors++; $display("FAIL q_b_scoreboard: got q=%h with no expected entry", q_b);
                end else begin
                    e = exp_b.pop_front();
                    if (q_b !== e) begin
                        errors++; $display("FAIL cont_q%0d: got %h required %h", n, q_b, e);
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        gate_n_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy_b, strobe_n_b} !== 2'b01) begin
            errors++; $display("FAIL cont_stop: got busy/strb %b required 01", {busy_b, strobe_n_b});
        end
        gate_n_b = 1'b0;
    endtask

    initial begin
        test_reset;
        test_reset_midscan;
`ifdef TDM_DEMUX_CONTINUOUS_EN
        test_continuous;
`else
        test_single_frame;
        test_glitch;
        test_abort;
        test_back_to_back;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
